// File: rtl/reg_file_bist.sv
// rtl/reg_file_bist.sv - march-style built-in self-test initiator for reg_file
//
// Purpose:
//   Drives reg_file's write and read ports through four phases. WR_A writes
//   pat(r) to r=1..31. RD_A reads both ports in opposite address orders and
//   checks the data. WR_B and RD_B repeat this with ~pat(r). A final write
//   of all ones to x0, followed by a read, confirms that x0 stays zero.
//   The first mismatch is captured. The run always goes to the end.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   start_i              begin a run; sampled in IDLE only
//   busy_o, done_o       run in progress; one-cycle end-of-run pulse
//   pass_o               no mismatch in the last run (valid from done_o)
//   fail_addr_o/_port_o  register index and port (0=rs1, 1=rs2) of first mismatch
//   fail_data_o          read value seen at first mismatch
//   rs1_addr_o, rs2_addr_o, rd_addr_o, rd_wdata_o, rd_wen_o   to reg_file
//   rs1_rdata_i, rs2_rdata_i                                  from reg_file
module reg_file_bist #(
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'hA5A5_5A5A
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [4:0]        fail_addr_o,
  output logic              fail_port_o,
  output logic [DATA_W-1:0] fail_data_o,
  output logic [4:0]        rs1_addr_o,
  output logic [4:0]        rs2_addr_o,
  output logic [4:0]        rd_addr_o,
  output logic [DATA_W-1:0] rd_wdata_o,
  output logic              rd_wen_o,
  input  logic [DATA_W-1:0] rs1_rdata_i,
  input  logic [DATA_W-1:0] rs2_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_RD_A, S_WR_B, S_RD_B, S_X0_WR, S_X0_RD, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          idx_q, idx_d;
  logic                pass_q, pass_d;
  logic [4:0]          fail_addr_q, fail_addr_d;
  logic                fail_port_q, fail_port_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [4:0]          rs1_addr_q, rs1_addr_d;
  logic [4:0]          rs2_addr_q, rs2_addr_d;
  logic [4:0]          rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   rd_wdata_q, rd_wdata_d;
  logic                rd_wen_q, rd_wen_d;

  logic                cmp;
  logic [DATA_W-1:0]   exp1, exp2;

  function automatic logic [DATA_W-1:0] pat(input logic [4:0] r);
    logic [31:0] p;
    p = SEED ^ ({27'd0, r} * 32'h0101_0101);
    return DATA_W'(p);
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_port_d = fail_port_q;
    fail_data_d = fail_data_q;
    cmp         = 1'b0;
    exp1        = '0;
    exp2        = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_WR_A;
          idx_d       = 5'd1;
          pass_d      = 1'b1;
          fail_addr_d = '0;
          fail_port_d = 1'b0;
          fail_data_d = '0;
        end
      end
      S_WR_A, S_WR_B: begin
        if (idx_q == 5'd31) begin
          state_d = (state_q == S_WR_A) ? S_RD_A : S_RD_B;
          idx_d   = 5'd1;
        end else begin
          idx_d = 5'(idx_q + 5'd1);
        end
      end
      S_RD_A, S_RD_B: begin
        cmp  = 1'b1;
        // The rs2 port walks downward, so rs2 reads address 32-idx, which is (0 - idx) mod 32.
        exp1 = pat(idx_q);
        exp2 = pat(5'd0 - idx_q);
        if (state_q == S_RD_B) begin
          exp1 = ~exp1;
          exp2 = ~exp2;
        end
        if (idx_q == 5'd31) begin
          state_d = (state_q == S_RD_A) ? S_WR_B : S_X0_WR;
          idx_d   = (state_q == S_RD_A) ? 5'd1 : 5'd0;
        end else begin
          idx_d = 5'(idx_q + 5'd1);
        end
      end
      S_X0_WR: state_d = S_X0_RD;
      S_X0_RD: begin
        cmp     = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // pass_q is still 1 only before the first mismatch, so it gates the capture.
    // rs1 is checked first, so rs1 wins when both ports miss in the same cycle.
    if (cmp) begin
      if (rs1_rdata_i != exp1) begin
        pass_d = 1'b0;
        if (pass_q) begin
          fail_addr_d = rs1_addr_q;
          fail_port_d = 1'b0;
          fail_data_d = rs1_rdata_i;
        end
      end else if (rs2_rdata_i != exp2) begin
        pass_d = 1'b0;
        if (pass_q) begin
          fail_addr_d = rs2_addr_q;
          fail_port_d = 1'b1;
          fail_data_d = rs2_rdata_i;
        end
      end
    end

    // The port drives come from the next state, so the outputs are registered
    // and line up with the state cycle they belong to.
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    rs1_addr_d = '0;
    rs2_addr_d = '0;
    rd_addr_d  = '0;
    rd_wdata_d = '0;
    rd_wen_d   = 1'b0;
    case (state_d)
      S_WR_A: begin
        rd_wen_d   = 1'b1;
        rd_addr_d  = idx_d;
        rd_wdata_d = pat(idx_d);
      end
      S_WR_B: begin
        rd_wen_d   = 1'b1;
        rd_addr_d  = idx_d;
        rd_wdata_d = ~pat(idx_d);
      end
      S_RD_A, S_RD_B: begin
        rs1_addr_d = idx_d;
        rs2_addr_d = 5'd0 - idx_d;
      end
      S_X0_WR: begin
        rd_wen_d   = 1'b1;
        rd_wdata_d = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_port_q <= 1'b0;
      fail_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rd_wdata_q  <= '0;
      rd_wen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_port_q <= fail_port_d;
      fail_data_q <= fail_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_wdata_q  <= rd_wdata_d;
      rd_wen_q    <= rd_wen_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_port_o = fail_port_q;
  assign fail_data_o = fail_data_q;
  assign rs1_addr_o  = rs1_addr_q;
  assign rs2_addr_o  = rs2_addr_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_wdata_o  = rd_wdata_q;
  assign rd_wen_o    = rd_wen_q;

endmodule

// File: tb/tb_reg_file_bist.sv
// tb/tb_reg_file_bist.sv - bench for reg_file_bist with a fault-injectable register file model
module tb_reg_file_bist;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass, fail_port, rd_wen;
  logic [4:0]  fail_addr, rs1_addr, rs2_addr, rd_addr;
  logic [31:0] fail_data, rd_wdata, rs1_rdata, rs2_rdata;

  always #5 clk = ~clk;

  reg_file_bist dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .fail_addr_o(fail_addr), .fail_port_o(fail_port), .fail_data_o(fail_data),
    .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr), .rd_addr_o(rd_addr),
    .rd_wdata_o(rd_wdata), .rd_wen_o(rd_wen),
    .rs1_rdata_i(rs1_rdata), .rs2_rdata_i(rs2_rdata)
  );

  // Register file model. The fault modes are: 0 healthy, 1 reg5 bit3 stuck-at-0, 2 x0 writable.
  logic [31:0] mem [0:31];
  int          fault_mode = 0;

  always @(posedge clk)
    if (rd_wen && (rd_addr != 5'd0 || fault_mode == 2)) mem[rd_addr] <= rd_wdata;

  function automatic logic [31:0] rdf(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return (fault_mode == 2) ? mem[0] : 32'd0;
    v = mem[a];
    if (fault_mode == 1 && a == 5'd5) v[3] = 1'b0;
    return v;
  endfunction

  assign rs1_rdata = rdf(rs1_addr);
  assign rs2_rdata = rdf(rs2_addr);

  function automatic logic [31:0] bpat(input int r);
    logic [7:0] b;
    b = 8'(r);
    return 32'hA5A5_5A5A ^ {4{b}};
  endfunction

  typedef struct {
    logic        pass;
    logic [4:0]  addr;
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic kick(input logic p, input logic [4:0] a, input logic pt, input logic [31:0] d, input bit push);
    exp_t e;
    e.pass = p; e.addr = a; e.port = pt; e.data = d;
    @(negedge clk);
    start = 1'b1;
    if (push) sb.push_back(e);
  endtask

  // Expects start=1 to be set already; the next rising edge is T0.
  task automatic run_bist(input int repulse_at, input int rst_at, input bit chain);
    int   busy_cnt;
    int   done_at;
    exp_t e;
    busy_cnt = 0;
    done_at  = 0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (repulse_at != 0 && k == repulse_at) start = 1'b1;
      if (repulse_at != 0 && k == repulse_at + 1) start = 1'b0;
      if (k == 1) begin
        checks++;
        if ({pass, fail_addr, fail_port, fail_data} !== {1'b1, 5'd0, 1'b0, 32'd0}) begin
          errors++; $display("FAIL start_clear: got pass=%0b addr=%0d port=%0b data=%h, expected 1 0 0 0", pass, fail_addr, fail_port, fail_data);
        end
        checks++;
        if ({rd_wen, rd_addr, rd_wdata, rs1_addr} !== {1'b1, 5'd1, bpat(1), 5'd0}) begin
          errors++; $display("FAIL wr_a_first: got wen=%0b addr=%0d wdata=%h rs1=%0d, expected 1 1 %h 0", rd_wen, rd_addr, rd_wdata, rs1_addr, bpat(1));
        end
      end
      if (k == 32) begin
        checks++;
        if ({rd_wen, rs1_addr, rs2_addr} !== {1'b0, 5'd1, 5'd31}) begin
          errors++; $display("FAIL rd_a_first: got wen=%0b rs1=%0d rs2=%0d, expected 0 1 31", rd_wen, rs1_addr, rs2_addr);
        end
      end
      if (k == 63) begin
        checks++;
        if ({rd_wen, rd_addr, rd_wdata} !== {1'b1, 5'd1, ~bpat(1)}) begin
          errors++; $display("FAIL wr_b_first: got wen=%0b addr=%0d wdata=%h, expected 1 1 %h", rd_wen, rd_addr, rd_wdata, ~bpat(1));
        end
      end
      if (rst_at != 0 && k == rst_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if ({rd_wen, busy, rd_addr, rd_wdata, pass} !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b0}) begin
          errors++; $display("FAIL mid_reset: got wen=%0b busy=%0b addr=%0d wdata=%h pass=%0b, expected all 0", rd_wen, busy, rd_addr, rd_wdata, pass);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rd_wen} !== 2'b00) begin
          errors++; $display("FAIL no_resume: got busy=%0b wen=%0b, expected 0 0", busy, rd_wen);
        end
        return;
      end
      if (k == 125) begin
        checks++;
        if ({rd_wen, rd_addr, rd_wdata} !== {1'b1, 5'd0, 32'hFFFF_FFFF}) begin
          errors++; $display("FAIL x0_wr: got wen=%0b addr=%0d wdata=%h, expected 1 0 ffffffff", rd_wen, rd_addr, rd_wdata);
        end
      end
      if (k == 126) begin
        checks++;
        if ({rd_wen, rs1_addr, rs2_addr, busy} !== {1'b0, 5'd0, 5'd0, 1'b1}) begin
          errors++; $display("FAIL x0_rd: got wen=%0b rs1=%0d rs2=%0d busy=%0b, expected 0 0 0 1", rd_wen, rs1_addr, rs2_addr, busy);
        end
      end
      if (done) begin
        done_at = k;
        break;
      end
    end
    checks++;
    if (done_at != 127) begin
      errors++; $display("FAIL done_cycle: got %0d, expected 127", done_at);
    end
    checks++;
    if (busy_cnt != 126) begin
      errors++; $display("FAIL busy_cycles: got %0d, expected 126", busy_cnt);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      e = sb.pop_front();
      if ({pass, fail_addr, fail_port, fail_data} !== {e.pass, e.addr, e.port, e.data}) begin
        errors++; $display("FAIL result: got pass=%0b addr=%0d port=%0b data=%h, expected %0b %0d %0b %h", pass, fail_addr, fail_port, fail_data, e.pass, e.addr, e.port, e.data);
      end
    end
    if (chain) begin
      // Start is held high through DONE, where it must be ignored, and is accepted in the IDLE cycle that follows.
      start = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++; $display("FAIL done_ignores_start: got busy=%0b done=%0b, expected 0 0", busy, done);
      end
    end else begin
      @(negedge clk);
      checks++;
      if ({done, busy, pass} !== {1'b0, 1'b0, e.pass}) begin
        errors++; $display("FAIL done_pulse_hold: got done=%0b busy=%0b pass=%0b, expected 0 0 %0b", done, busy, pass, e.pass);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, pass, fail_addr, fail_port, fail_data, rs1_addr, rs2_addr, rd_addr, rd_wdata, rd_wen} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%0b done=%0b pass=%0b wen=%0b, expected all 0", busy, done, pass, rd_wen);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, rd_wen} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: got busy=%0b wen=%0b, expected 0 0", busy, rd_wen);
    end
  endtask

  task automatic test_healthy();
    fault_mode = 0;
    kick(1'b1, 5'd0, 1'b0, 32'd0, 1'b1);
    run_bist(0, 0, 1'b0);
    checks++;
    if (mem[5] !== 32'h5F5F_A0A0) begin
      errors++; $display("FAIL reg5_final: got %h, expected 5f5fa0a0", mem[5]);
    end
  endtask

  task automatic test_stuck_bit();
    fault_mode = 1;
    kick(1'b0, 5'd5, 1'b0, bpat(5) & ~32'h8, 1'b1);
    run_bist(0, 0, 1'b0);
    fault_mode = 0;
  endtask

  task automatic test_x0_writable();
    fault_mode = 2;
    kick(1'b0, 5'd0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    run_bist(0, 0, 1'b0);
    fault_mode = 0;
  endtask

  task automatic test_repulse();
    kick(1'b1, 5'd0, 1'b0, 32'd0, 1'b1);
    run_bist(40, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    kick(1'b1, 5'd0, 1'b0, 32'd0, 1'b0);
    run_bist(0, 70, 1'b0);
    kick(1'b1, 5'd0, 1'b0, 32'd0, 1'b1);
    run_bist(0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    fault_mode = 1;
    kick(1'b0, 5'd5, 1'b0, bpat(5) & ~32'h8, 1'b1);
    run_bist(0, 0, 1'b1);
    fault_mode = 0;
    sb.push_back('{pass: 1'b1, addr: 5'd0, port: 1'b0, data: 32'd0});
    run_bist(0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_healthy();
    test_stuck_bit();
    test_x0_writable();
    test_repulse();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
